video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
Parametrised, runtime-reconfigurable raster timing generator, the next generation of the fixed 800x600 sync generator. It produces sync, blank and data-enable signals plus pixel/line coordinates, advancing on a pixel clock enable. New timing can be loaded at runtime and takes effect only at frame boundaries. It sits between the core clock domain and the MiSTer video output/scaler path.

Parameters:
HW, 12, width of horizontal fields and counter
VW, 11, width of vertical fields and counter
FCW, 8, frame counter width
H_ACTIVE, 800, default active pixels per line
H_FP, 24, default horizontal front porch
H_SYNC, 72, default hsync width
H_BP, 128, default horizontal back porch
V_ACTIVE, 600, default active lines
V_FP, 1, default vertical front porch
V_SYNC, 2, default vsync width
V_BP, 22, default vertical back porch
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)

Ports:
clk_vid  in  1  video clock
reset_n  in  1  asynchronous active-low reset
ce_pix  in  1  pixel clock enable; all counters advance only when 1
cfg_wr  in  1  single-cycle strobe capturing cfg_h/cfg_v into the shadow register
cfg_h  in  4*HW  {h_bp, h_sync, h_fp, h_active}; h_active at [HW-1:0]
cfg_v  in  4*VW  {v_bp, v_sync, v_fp, v_active}; v_active at [VW-1:0]
cfg_pending  out  1  shadow holds timing not yet applied
cfg_err  out  1  last cfg_wr rejected
hsync  out  1  horizontal sync, polarity per HS_POL
vsync  out  1  vertical sync, polarity per VS_POL
hblank  out  1  hpos >= h_active
vblank  out  1  vpos >= v_active
de  out  1  ~hblank & ~vblank
hpos  out  HW  pixel counter
vpos  out  VW  line counter
line_start  out  1  high while hpos == 0
frame_start  out  1  high while hpos == 0 and vpos == 0
frame_cnt  out  FCW  completed-frame counter

Behaviour:
- Reset (asynchronous, reset_n=0): hpos=0, vpos=0, active and shadow timing = parameter defaults, cfg_pending=0, cfg_err=0, frame_cnt=0. Outputs: hsync=~HS_POL, vsync=~VS_POL, hblank=0, vblank=0, de=1, line_start=1, frame_start=1.
- Totals: H_T = h_active+h_fp+h_sync+h_bp and V_T likewise, computed at 2 extra bits of width. hpos runs 0..H_T-1. vpos increments when hpos wraps and runs 0..V_T-1.
- On ce_pix=0, all state is held and the outputs do not change.
- All outputs are registered and aligned to the current hpos/vpos, with zero latency relative to the coordinates.
- hsync is active for h_active+h_fp <= hpos < h_active+h_fp+h_sync. vsync is active for v_active+v_fp <= vpos < v_active+v_fp+v_sync. vsync changes only at hpos == 0.
- Frame wrap event: ce_pix=1, hpos==H_T-1 and vpos==V_T-1. On this event frame_cnt increments (wrapping modulo 2^FCW). If cfg_pending=1, shadow is copied to active timing and cfg_pending is cleared. The new timing is effective from hpos=0, vpos=0.
- cfg_wr validation: reject if h_active, h_sync, v_active or v_sync is 0, or if H_T > 2^HW, or if V_T > 2^VW.
  - Rejected write: cfg_err=1; shadow, cfg_pending and active timing unchanged.
  - Accepted write: shadow updated, cfg_pending=1, cfg_err=0.
- cfg_wr is independent of ce_pix.
- cfg_wr coinciding with a frame wrap: the transfer uses the old shadow if cfg_pending was 1. The new values land in the shadow and cfg_pending ends at 1, so they apply at the following wrap.
- Repeated cfg_wr before a wrap: the last accepted write wins.
- Reset mid-operation discards any pending configuration.

Test Plan:
- Defaults, ce_pix=1 constantly -> H_T=1024, V_T=625.
  - hblank rises at hpos 800; hsync low for hpos 824..895.
  - vsync low for vpos 601..602; frame_start every 640000 clocks.
- ce_pix asserted every 2nd clock -> line_start period 2048 clocks; all outputs stable on ce_pix=0 cycles.
- cfg_wr at vpos 300 with h=640/16/96/48, v=480/10/2/33 -> cfg_pending=1 and old 1024-pixel lines continue to the frame end. Then H_T=800, V_T=525, hsync active for hpos 656..751, cfg_pending=0.
- cfg_wr with h_sync=0 -> cfg_err=1, cfg_pending unchanged, timing unchanged. A following valid cfg_wr clears cfg_err.
- reset_n deasserted at hpos=500, vpos=200, with a pending config -> immediately hpos=0, vpos=0, defaults active, cfg_pending=0. After release, first line timing = 1024 pixels.
- Run 256 frames -> frame_cnt wraps 255->0 exactly at a frame_start. cfg_wr on the wrap cycle -> applied at the next frame, not the current one.

Source files
------------

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Brief    : Runtime-reconfigurable raster timing generator with shadowed
//            timing that is swapped in only at frame boundaries.
// Revision : 1.0
// ============================================================================
module video_timing_gen #(
  parameter int HW       = 12,
  parameter int VW       = 11,
  parameter int FCW      = 8,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 72,
  parameter int H_BP     = 128,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 22,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic            clk_vid,
  input  logic            reset_n,
  input  logic            ce_pix,
  input  logic            cfg_wr,
  input  logic [4*HW-1:0] cfg_h,
  input  logic [4*VW-1:0] cfg_v,
  output logic            cfg_pending,
  output logic            cfg_err,
  output logic            hsync,
  output logic            vsync,
  output logic            hblank,
  output logic            vblank,
  output logic            de,
  output logic [HW-1:0]   hpos,
  output logic [VW-1:0]   vpos,
  output logic            line_start,
  output logic            frame_start,
  output logic [FCW-1:0]  frame_cnt
);

  localparam logic [4*HW-1:0] c_CFG_H_DEF = {HW'(H_BP), HW'(H_SYNC), HW'(H_FP), HW'(H_ACTIVE)};
  localparam logic [4*VW-1:0] c_CFG_V_DEF = {VW'(V_BP), VW'(V_SYNC), VW'(V_FP), VW'(V_ACTIVE)};
  localparam logic [HW+1:0]   c_H_LIM     = {2'b01, {HW{1'b0}}};
  localparam logic [VW+1:0]   c_V_LIM     = {2'b01, {VW{1'b0}}};

  // Totals carry two extra bits so four maximal fields cannot overflow.
  function automatic logic [HW+1:0] h_total(input logic [4*HW-1:0] c);
    h_total = {2'b00, c[HW-1:0]} + {2'b00, c[2*HW-1:HW]}
            + {2'b00, c[3*HW-1:2*HW]} + {2'b00, c[4*HW-1:3*HW]};
  endfunction

  function automatic logic [VW+1:0] v_total(input logic [4*VW-1:0] c);
    v_total = {2'b00, c[VW-1:0]} + {2'b00, c[2*VW-1:VW]}
            + {2'b00, c[3*VW-1:2*VW]} + {2'b00, c[4*VW-1:3*VW]};
  endfunction

  logic [4*HW-1:0] r_act_h, r_shd_h, w_nxt_h;
  logic [4*VW-1:0] r_act_v, r_shd_v, w_nxt_v;
  logic [HW+1:0]   w_ht, w_new_ht, w_hx, w_ha, w_hs_lo, w_hs_hi;
  logic [VW+1:0]   w_vt, w_new_vt, w_vx, w_va, w_vs_lo, w_vs_hi;
  logic [HW-1:0]   w_nxt_hpos;
  logic [VW-1:0]   w_nxt_vpos;
  logic            w_h_last, w_v_last, w_wrap, w_cfg_ok;
  logic            w_hb, w_vb, w_hs_act, w_vs_act;

  assign w_ht     = h_total(r_act_h);
  assign w_vt     = v_total(r_act_v);
  assign w_new_ht = h_total(cfg_h);
  assign w_new_vt = v_total(cfg_v);

  assign w_cfg_ok = (|cfg_h[HW-1:0]) && (|cfg_h[3*HW-1:2*HW]) &&
                    (|cfg_v[VW-1:0]) && (|cfg_v[3*VW-1:2*VW]) &&
                    (w_new_ht <= c_H_LIM) && (w_new_vt <= c_V_LIM);

  assign w_h_last   = ({2'b00, hpos} == (w_ht - (HW+2)'(1)));
  assign w_v_last   = ({2'b00, vpos} == (w_vt - (VW+2)'(1)));
  assign w_wrap     = ce_pix && w_h_last && w_v_last;
  assign w_nxt_hpos = w_h_last ? '0 : hpos + HW'(1);
  assign w_nxt_vpos = w_h_last ? (w_v_last ? '0 : vpos + VW'(1)) : vpos;

  // Timing used to decode the coordinates the counters are about to take.
  assign w_nxt_h = (w_wrap && cfg_pending) ? r_shd_h : r_act_h;
  assign w_nxt_v = (w_wrap && cfg_pending) ? r_shd_v : r_act_v;

  assign w_hx     = {2'b00, w_nxt_hpos};
  assign w_ha     = {2'b00, w_nxt_h[HW-1:0]};
  assign w_hs_lo  = w_ha + {2'b00, w_nxt_h[2*HW-1:HW]};
  assign w_hs_hi  = w_hs_lo + {2'b00, w_nxt_h[3*HW-1:2*HW]};
  assign w_hb     = (w_hx >= w_ha);
  assign w_hs_act = (w_hx >= w_hs_lo) && (w_hx < w_hs_hi);

  assign w_vx     = {2'b00, w_nxt_vpos};
  assign w_va     = {2'b00, w_nxt_v[VW-1:0]};
  assign w_vs_lo  = w_va + {2'b00, w_nxt_v[2*VW-1:VW]};
  assign w_vs_hi  = w_vs_lo + {2'b00, w_nxt_v[3*VW-1:2*VW]};
  assign w_vb     = (w_vx >= w_va);
  assign w_vs_act = (w_vx >= w_vs_lo) && (w_vx < w_vs_hi);

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      r_act_h     <= c_CFG_H_DEF;
      r_act_v     <= c_CFG_V_DEF;
      r_shd_h     <= c_CFG_H_DEF;
      r_shd_v     <= c_CFG_V_DEF;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
      frame_cnt   <= '0;
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      de          <= 1'b1;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      r_act_h <= w_nxt_h;
      r_act_v <= w_nxt_v;
      if (w_wrap) begin
        frame_cnt   <= frame_cnt + FCW'(1);
        cfg_pending <= 1'b0;
      end
      // A write on the wrap cycle lands after the transfer, so it stays pending.
      if (cfg_wr) begin
        if (w_cfg_ok) begin
          r_shd_h     <= cfg_h;
          r_shd_v     <= cfg_v;
          cfg_pending <= 1'b1;
          cfg_err     <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (ce_pix) begin
        hpos        <= w_nxt_hpos;
        vpos        <= w_nxt_vpos;
        hblank      <= w_hb;
        vblank      <= w_vb;
        de          <= !w_hb && !w_vb;
        hsync       <= w_hs_act ? HS_POL : ~HS_POL;
        vsync       <= w_vs_act ? VS_POL : ~VS_POL;
        line_start  <= (w_nxt_hpos == '0);
        frame_start <= (w_nxt_hpos == '0) && (w_nxt_vpos == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Brief    : Directed, table-driven bench for video_timing_gen (short vertical
//            defaults so complete frames fit in a short run).
// Revision : 1.0
// ============================================================================
module tb_video_timing_gen;
  localparam int HW  = 12;
  localparam int VW  = 11;
  localparam int FCW = 8;

  logic            clk_vid = 1'b0;
  logic            reset_n = 1'b0;
  logic            ce_pix  = 1'b0;
  logic            cfg_wr  = 1'b0;
  logic [4*HW-1:0] cfg_h   = '0;
  logic [4*VW-1:0] cfg_v   = '0;
  logic            cfg_pending, cfg_err, hsync, vsync, hblank, vblank, de;
  logic [HW-1:0]   hpos;
  logic [VW-1:0]   vpos;
  logic            line_start, frame_start;
  logic [FCW-1:0]  frame_cnt;

  int checks = 0;
  int errors = 0;

  video_timing_gen #(
    .HW(HW), .VW(VW), .FCW(FCW),
    .H_ACTIVE(800), .H_FP(24), .H_SYNC(72), .H_BP(128),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix), .cfg_wr(cfg_wr),
    .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .de(de),
    .hpos(hpos), .vpos(vpos), .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  always #5 clk_vid = ~clk_vid;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct { int h; logic hb; logic hs; logic ls; } dec_t;
  typedef struct { logic [4*HW-1:0] h; logic [4*VW-1:0] v; logic err; logic pend; } cfg_t;

  dec_t dtab[16];
  cfg_t ctab[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_vid);
    #1;
  endtask

  task automatic wait_pos(input int h, input int v, input int lim, output int n);
    n = 0;
    while (!(hpos == h && vpos == v) && n < lim) begin
      tick();
      n++;
    end
    if (!(hpos == h && vpos == v)) begin
      checks++;
      errors++;
      $display("FAIL wait_pos(%0d,%0d): stuck at %0d,%0d", h, v, hpos, vpos);
    end
  endtask

  function automatic logic [4*HW-1:0] mkh(input int a, input int fp, input int s, input int bp);
    mkh = {bp[HW-1:0], s[HW-1:0], fp[HW-1:0], a[HW-1:0]};
  endfunction

  function automatic logic [4*VW-1:0] mkv(input int a, input int fp, input int s, input int bp);
    mkv = {bp[VW-1:0], s[VW-1:0], fp[VW-1:0], a[VW-1:0]};
  endfunction

  function automatic logic [39:0] snap();
    snap = {cfg_pending, cfg_err, hsync, vsync, hblank, vblank, de,
            hpos, vpos, line_start, frame_start, frame_cnt};
  endfunction

  task automatic write_cfg(input logic [4*HW-1:0] h, input logic [4*VW-1:0] v);
    cfg_h  = h;
    cfg_v  = v;
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic run_tab(input int lo, input int hi, input int v);
    int n;
    for (int i = lo; i <= hi; i++) begin
      wait_pos(dtab[i].h, v, 2100, n);
      check($sformatf("hblank@%0d", dtab[i].h), hblank, dtab[i].hb);
      check($sformatf("hsync@%0d", dtab[i].h), hsync, dtab[i].hs);
      check($sformatf("de@%0d", dtab[i].h), de, !dtab[i].hb);
      check($sformatf("line_start@%0d", dtab[i].h), line_start, dtab[i].ls);
    end
  endtask

  initial begin : main
    int n;
    int bad;
    int rise[$];
    logic [39:0] pre;
    logic [HW-1:0] ph;

    // 800/24/72/128 line: blank from 800, sync low 824..895
    dtab[0]  = '{0,    1'b0, 1'b1, 1'b1};
    dtab[1]  = '{799,  1'b0, 1'b1, 1'b0};
    dtab[2]  = '{800,  1'b1, 1'b1, 1'b0};
    dtab[3]  = '{823,  1'b1, 1'b1, 1'b0};
    dtab[4]  = '{824,  1'b1, 1'b0, 1'b0};
    dtab[5]  = '{895,  1'b1, 1'b0, 1'b0};
    dtab[6]  = '{896,  1'b1, 1'b1, 1'b0};
    dtab[7]  = '{1023, 1'b1, 1'b1, 1'b0};
    // 640/16/96/48 line: blank from 640, sync low 656..751
    dtab[8]  = '{0,    1'b0, 1'b1, 1'b1};
    dtab[9]  = '{639,  1'b0, 1'b1, 1'b0};
    dtab[10] = '{640,  1'b1, 1'b1, 1'b0};
    dtab[11] = '{655,  1'b1, 1'b1, 1'b0};
    dtab[12] = '{656,  1'b1, 1'b0, 1'b0};
    dtab[13] = '{751,  1'b1, 1'b0, 1'b0};
    dtab[14] = '{752,  1'b1, 1'b1, 1'b0};
    dtab[15] = '{799,  1'b1, 1'b1, 1'b0};

    ctab[0] = '{mkh(640, 16, 0, 48),   mkv(480, 10, 2, 33), 1'b1, 1'b0};
    ctab[1] = '{mkh(640, 16, 96, 48),  mkv(0, 10, 2, 33),   1'b1, 1'b0};
    ctab[2] = '{mkh(4000, 0, 96, 1),   mkv(480, 10, 2, 33), 1'b1, 1'b0};
    ctab[3] = '{mkh(640, 16, 96, 48),  mkv(2000, 0, 48, 1), 1'b1, 1'b0};
    ctab[4] = '{mkh(4000, 0, 95, 1),   mkv(2000, 0, 47, 1), 1'b0, 1'b1};
    ctab[5] = '{mkh(640, 16, 0, 48),   mkv(480, 10, 2, 33), 1'b1, 1'b1};
    ctab[6] = '{mkh(640, 16, 96, 48),  mkv(480, 10, 0, 33), 1'b1, 1'b1};
    ctab[7] = '{mkh(0, 16, 96, 48),    mkv(480, 10, 2, 33), 1'b1, 1'b1};

    // Reset state
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    check("rst_hpos", hpos, 0);
    check("rst_vpos", vpos, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_hblank", hblank, 0);
    check("rst_vblank", vblank, 0);
    check("rst_de", de, 1);
    check("rst_line_start", line_start, 1);
    check("rst_frame_start", frame_start, 1);
    check("rst_pending", cfg_pending, 0);
    check("rst_err", cfg_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);

    // Config validation with the raster frozen
    ce_pix = 1'b0;
    for (int i = 0; i < 8; i++) begin
      write_cfg(ctab[i].h, ctab[i].v);
      check($sformatf("cfg%0d_err", i), cfg_err, ctab[i].err);
      check($sformatf("cfg%0d_pending", i), cfg_pending, ctab[i].pend);
      check($sformatf("cfg%0d_hpos_hold", i), hpos, 0);
    end

    // Default line decode, continuous ce
    ce_pix = 1'b1;
    run_tab(0, 7, 0);
    tick();
    check("def_wrap_hpos", hpos, 0);
    check("def_wrap_vpos", vpos, 1);

    // ce every second clock
    bad = 0;
    for (int i = 0; i < 4200; i++) begin
      ce_pix = (i % 2 == 0);
      pre = snap();
      ph  = hpos;
      tick();
      if (!ce_pix && snap() != pre) bad++;
      if (hpos == 0 && ph != 0) rise.push_back(i);
    end
    ce_pix = 1'b1;
    check("ce_hold_stable", bad, 0);
    check("ce_line_rises", rise.size(), 2);
    if (rise.size() >= 2) check("ce_line_period", rise[1] - rise[0], 2048);

    // Mid-frame reconfiguration to 640x480 timing, deferred to the frame end
    wait_pos(100, 4, 3000, n);
    write_cfg(mkh(640, 16, 96, 48), mkv(480, 10, 2, 33));
    check("vga_pending", cfg_pending, 1);
    check("vga_err_cleared", cfg_err, 0);
    wait_pos(0, 5, 1100, n);
    for (int v = 5; v <= 9; v++) begin
      check($sformatf("vsync@v%0d", v), vsync, (v == 7 || v == 8) ? 0 : 1);
      check($sformatf("vblank@v%0d", v), vblank, (v >= 6) ? 1 : 0);
      check($sformatf("de@v%0d", v), de, (v < 6) ? 1 : 0);
      tick();
      wait_pos(0, (v + 1) % 10, 1100, n);
      check($sformatf("old_line_len@v%0d", v), n + 1, 1024);
    end
    check("vga_frame_start", frame_start, 1);
    check("vga_frame_cnt", frame_cnt, 1);
    check("vga_pending_clr", cfg_pending, 0);
    check("vga_vsync_f0", vsync, 1);
    check("vga_vblank_f0", vblank, 0);
    run_tab(8, 15, 0);
    tick();
    check("vga_wrap_hpos", hpos, 0);
    check("vga_wrap_vpos", vpos, 1);

    // Asynchronous reset with a pending config
    write_cfg(mkh(2, 0, 1, 1), mkv(2, 0, 1, 0));
    check("pre_rst_pending", cfg_pending, 1);
    wait_pos(500, 2, 2000, n);
    reset_n = 1'b0;
    #1;
    check("arst_hpos", hpos, 0);
    check("arst_vpos", vpos, 0);
    check("arst_pending", cfg_pending, 0);
    check("arst_frame_cnt", frame_cnt, 0);
    check("arst_frame_start", frame_start, 1);
    check("arst_hsync", hsync, 1);
    tick();
    tick();
    check("arst_hold_hpos", hpos, 0);
    reset_n = 1'b1;
    run_tab(0, 7, 0);
    tick();
    check("post_rst_wrap_hpos", hpos, 0);
    check("post_rst_wrap_vpos", vpos, 1);

    // Tiny raster (4x3) to sweep frame_cnt through its wrap
    write_cfg(mkh(2, 0, 1, 1), mkv(2, 0, 1, 0));
    wait_pos(0, 0, 11000, n);
    check("tiny_frame_cnt", frame_cnt, 1);
    n = 0;
    while (frame_cnt != 8'd255 && n < 4000) begin
      tick();
      n++;
    end
    check("fc_reach_255", frame_cnt, 255);
    n = 0;
    while (frame_cnt == 8'd255 && n < 50) begin
      tick();
      n++;
    end
    check("fc_wrap_value", frame_cnt, 0);
    check("fc_wrap_frame_start", frame_start, 1);
    check("fc_wrap_period", n, 12);

    // Write pending, then a second write on the wrap cycle itself
    write_cfg(mkh(3, 0, 1, 1), mkv(2, 0, 1, 0));
    check("t2_pending", cfg_pending, 1);
    wait_pos(3, 2, 20, n);
    cfg_h  = mkh(4, 0, 1, 1);
    cfg_v  = mkv(2, 0, 1, 0);
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    check("wrapwr_hpos", hpos, 0);
    check("wrapwr_vpos", vpos, 0);
    check("wrapwr_pending", cfg_pending, 1);
    tick();
    wait_pos(0, 1, 20, n);
    check("t2_line_len", n + 1, 5);
    wait_pos(0, 0, 40, n);
    check("t3_pending_clr", cfg_pending, 0);
    tick();
    wait_pos(0, 1, 20, n);
    check("t3_line_len", n + 1, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
